// File: rtl/j2_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : j2_sequencer_pkg
//  Description : Shared constants for the J2 core: sequencer state encoding,
//                instruction opcode classes, ALU function codes and the
//                func-field codes that select stack/bus side effects.
//  Revision    : 1.0  initial release
// ============================================================================
package j2_sequencer_pkg;

    // Sequencer state encoding (2-bit)
    localparam logic [1:0] c_ST_REBOOT   = 2'd0;
    localparam logic [1:0] c_ST_FETCH    = 2'd1;
    localparam logic [1:0] c_ST_EXECUTE  = 2'd2;
    localparam logic [1:0] c_ST_BUS_WAIT = 2'd3;

    // Opcode classes in instruction[15:13]; a literal is any word with bit 15 set
    localparam logic       c_OP_LIT_MSB = 1'b1;
    localparam logic [2:0] c_OP_JMP     = 3'b000;
    localparam logic [2:0] c_OP_CJMP    = 3'b001;
    localparam logic [2:0] c_OP_CALL    = 3'b010;
    localparam logic [2:0] c_OP_ALU     = 3'b011;

    // ALU function codes in instruction[11:8] that read the data bus
    localparam logic [3:0] c_ALU_MEMRD = 4'b1100;
    localparam logic [3:0] c_ALU_IORD  = 4'b1101;

    // Func-field codes in instruction[6:4]
    localparam logic [2:0] c_FUNC_DSW  = 3'd1;
    localparam logic [2:0] c_FUNC_RSW  = 3'd2;
    localparam logic [2:0] c_FUNC_MEMW = 3'd3;
    localparam logic [2:0] c_FUNC_IOW  = 3'd4;

endpackage : j2_sequencer_pkg
`default_nettype wire

// File: rtl/j2_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : j2_sequencer
//  Description : Multi-cycle fetch/execute controller of the J2 core. Holds
//                PC, data/return stack pointers and top-of-stack, fetches
//                over a req/ack instruction port, stalls on data-bus accesses
//                and commits the combinational ALU's next-state outputs.
//  Ports       : clk/reset           - clock, synchronous active-high reset
//                imem_*              - instruction fetch request/ack/data
//                instruction, program_counter, is_reboot -> ALU
//                *_second, *_next_*, program_counter_next <- ALU
//                data_stack_pointer_top, return_stack_pointer_top,
//                data_stack_top      - registered architectural state
//                memory_write_enable, io_write_enable - ALU bus writes
//                bus_req/bus_ack     - data-bus handshake
//                stack_commit        - one-cycle commit strobe
//                retired_count       - instructions committed since reset
//  Revision    : 1.0  initial release
// ============================================================================
module j2_sequencer
    import j2_sequencer_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          DEPTH    = 4,
    parameter logic [12:0] RESET_PC = 13'd0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [12:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_data,
    output logic [15:0]      instruction,
    output logic [12:0]      program_counter,
    input  logic [12:0]      program_counter_next,
    output logic             is_reboot,
    output logic [DEPTH-1:0] data_stack_pointer_top,
    input  logic [DEPTH-1:0] data_stack_pointer_second,
    output logic [DEPTH-1:0] return_stack_pointer_top,
    input  logic [DEPTH-1:0] return_stack_pointer_second,
    output logic [WIDTH-1:0] data_stack_top,
    input  logic [WIDTH-1:0] data_stack_next_top,
    input  logic             memory_write_enable,
    input  logic             io_write_enable,
    output logic             bus_req,
    input  logic             bus_ack,
    output logic             stack_commit,
    output logic [31:0]      retired_count
);

    // An instruction touches the data bus when it is an ALU op that either
    // writes memory/IO through the func field or reads memory/IO via its
    // ALU function code.
    function automatic logic f_need_bus(input logic [15:0] insn);
        f_need_bus = (insn[15:13] == c_OP_ALU) &&
                     ((insn[6:4]  == c_FUNC_MEMW) || (insn[6:4]  == c_FUNC_IOW) ||
                      (insn[11:8] == c_ALU_MEMRD) || (insn[11:8] == c_ALU_IORD));
    endfunction

    logic [1:0]       r_state;
    logic [12:0]      r_pc;
    logic [DEPTH-1:0] r_dsp;
    logic [DEPTH-1:0] r_rsp;
    logic [WIDTH-1:0] r_t;
    logic [15:0]      r_insn;
    logic [31:0]      r_retired;

    logic             w_need_bus;
    logic             w_commit;

    assign w_need_bus = f_need_bus(r_insn);

    // Reset aborts the instruction in flight, so a bus_ack landing in the
    // reset cycle must not produce a commit.
    assign w_commit = !reset &&
                      (((r_state == c_ST_EXECUTE)  && !w_need_bus) ||
                       ((r_state == c_ST_BUS_WAIT) && bus_ack));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_REBOOT;
            r_pc      <= RESET_PC;
            r_dsp     <= '0;
            r_rsp     <= '0;
            r_t       <= '0;
            r_insn    <= 16'h0000;
            r_retired <= 32'd0;
        end else begin
            case (r_state)
                c_ST_REBOOT: r_state <= c_ST_FETCH;
                c_ST_FETCH: begin
                    if (imem_ack) begin
                        r_insn  <= imem_data;
                        r_state <= c_ST_EXECUTE;
                    end
                end
                c_ST_EXECUTE: r_state <= w_need_bus ? c_ST_BUS_WAIT : c_ST_FETCH;
                c_ST_BUS_WAIT: begin
                    if (bus_ack) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                default: r_state <= c_ST_REBOOT;
            endcase

            // Pointer wrap is whatever the ALU computed modulo 2^DEPTH
            if (w_commit) begin
                r_pc      <= program_counter_next;
                r_dsp     <= data_stack_pointer_second;
                r_rsp     <= return_stack_pointer_second;
                r_t       <= data_stack_next_top;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign imem_req                 = (r_state == c_ST_FETCH);
    assign imem_addr                = r_pc;
    assign instruction              = r_insn;
    assign program_counter          = r_pc;
    assign is_reboot                = (r_state == c_ST_REBOOT);
    assign data_stack_pointer_top   = r_dsp;
    assign return_stack_pointer_top = r_rsp;
    assign data_stack_top           = r_t;
    assign bus_req                  = (r_state == c_ST_BUS_WAIT);
    assign stack_commit             = w_commit;
    assign retired_count            = r_retired;

    // A bus write from the ALU is only legal for an instruction the decode
    // classified as a bus access; otherwise it would never be stalled for.
    a_write_needs_bus : assert property (@(posedge clk) disable iff (reset)
        ((r_state == c_ST_EXECUTE) && (memory_write_enable || io_write_enable)) |-> w_need_bus);

endmodule : j2_sequencer
`default_nettype wire
